// File: rtl/romix_vmem_ctrl.sv
// romix_vmem_ctrl
// ----------------
// Sequences one scrypt ROMix job's traffic to the scratchpad V held in a
// single-port BRAM. First DEPTH sequential writes V[i] = X, then DEPTH
// data-dependent reads V[key mod N], where key is the Integerify word.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start                   job start pulse (only honoured when idle)
//   o_busy, o_done            job in progress / one-cycle completion pulse
//   i_wr_valid, i_wr_data     write beat stream from BlockMix
//   o_wr_ready                write beat accepted when valid & ready
//   i_rd_valid, i_rd_key      read request stream (Integerify word)
//   o_rd_ready                read request accepted when valid & ready
//   o_rdata_valid, o_rdata    read response strobe and data (no backpressure)
//   o_mem_addr, o_mem_write,
//   o_mem_data                registered BRAM address / write enable / write data
//   i_mem_data                BRAM read data (1-cycle registered, read-first)
//
// Build option
//   VMEM_RD_PIPE_EN  defined: read requests accepted every READ cycle, up to two
//                    in flight. Undefined: one outstanding read at a time.
module romix_vmem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 1024,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic                  i_wr_valid,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    input  logic                  i_rd_valid,
    input  logic [31:0]           i_rd_key,
    output logic                  o_rd_ready,
    output logic                  o_rdata_valid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_write,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic [DATA_WIDTH-1:0] i_mem_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // One extra bit so a full count of DEPTH is representable without wrap.
    localparam int unsigned           CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      CNT_ONE   = 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      CNT_DEPTH = CNT_W'(DEPTH);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic [CNT_W-1:0]      r_rd_issued;
    logic [CNT_W-1:0]      r_rd_done;
    // [0]: request presented to BRAM this cycle, [1]: BRAM data valid this cycle
    logic [1:0]            r_rd_pipe;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_write;
    logic [DATA_WIDTH-1:0] r_mem_data;

    logic w_wr_ready;
    logic w_rd_ready;
    logic w_wr_hs;
    logic w_rd_hs;
    logic w_unused_key_hi;

    // Index is key mod N; upper key bits are intentionally dropped.
    assign w_unused_key_hi = ^i_rd_key[31:ADDR_WIDTH];

    assign w_wr_ready = (r_state == ST_WRITE);
`ifdef VMEM_RD_PIPE_EN
    assign w_rd_ready = (r_state == ST_READ);
`else
    // Hold off until the previous read has returned its data.
    assign w_rd_ready = (r_state == ST_READ) && (r_rd_pipe == 2'b00);
`endif

    assign w_wr_hs = w_wr_ready & i_wr_valid;
    assign w_rd_hs = w_rd_ready & i_rd_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_wr_cnt    <= '0;
            r_rd_issued <= '0;
            r_rd_done   <= '0;
            r_rd_pipe   <= 2'b00;
            r_mem_addr  <= '0;
            r_mem_write <= 1'b0;
            r_mem_data  <= '0;
        end else begin
            r_rd_pipe   <= {r_rd_pipe[0], w_rd_hs};
            r_mem_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state     <= ST_WRITE;
                        r_wr_cnt    <= '0;
                        r_rd_issued <= '0;
                        r_rd_done   <= '0;
                    end
                end
                ST_WRITE: begin
                    if (w_wr_hs) begin
                        r_mem_addr  <= r_wr_cnt[ADDR_WIDTH-1:0];
                        r_mem_write <= 1'b1;
                        r_mem_data  <= i_wr_data;
                        r_wr_cnt    <= r_wr_cnt + CNT_ONE;
                        if (r_wr_cnt == CNT_LAST) begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (w_rd_hs) begin
                        r_mem_addr  <= i_rd_key[ADDR_WIDTH-1:0];
                        r_rd_issued <= r_rd_issued + CNT_ONE;
                        if (r_rd_issued == CNT_LAST) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                    if (r_rd_pipe[1]) begin
                        r_rd_done <= r_rd_done + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (r_rd_done == CNT_DEPTH) begin
                        r_state <= ST_IDLE;
                    end else if (r_rd_pipe[1]) begin
                        r_rd_done <= r_rd_done + CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_DRAIN) && (r_rd_done == CNT_DEPTH);
    assign o_wr_ready    = w_wr_ready;
    assign o_rd_ready    = w_rd_ready;
    assign o_rdata_valid = r_rd_pipe[1];
    assign o_rdata       = i_mem_data;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_write   = r_mem_write;
    assign o_mem_data    = r_mem_data;

endmodule

// File: tb/tb_romix_vmem_ctrl.sv
module tb_romix_vmem_ctrl;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned DP = 16;
`ifdef VMEM_RD_PIPE_EN
    localparam int HS_GAP = 1;
`else
    localparam int HS_GAP = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, busy, done;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [31:0]   rd_key;
    logic          rdata_valid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    romix_vmem_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .o_busy        (busy),
        .o_done        (done),
        .i_wr_valid    (wr_valid),
        .i_wr_data     (wr_data),
        .o_wr_ready    (wr_ready),
        .i_rd_valid    (rd_valid),
        .i_rd_key      (rd_key),
        .o_rd_ready    (rd_ready),
        .o_rdata_valid (rdata_valid),
        .o_rdata       (rdata),
        .o_mem_addr    (mem_addr),
        .o_mem_write   (mem_write),
        .o_mem_data    (mem_wdata),
        .i_mem_data    (mem_rdata)
    );

    // Single-port read-first BRAM with registered output.
    logic [DW-1:0] bram [DP];
    always @(posedge clk) begin
        if (mem_write) bram[mem_addr] <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int c; logic [AW-1:0] addr; logic [DW-1:0] data; } wexp_t;
    typedef struct { int c; logic [DW-1:0] data; } rexp_t;
    wexp_t         wq[$];
    rexp_t         rq[$];
    logic [DW-1:0] vmodel [DP];
    logic [31:0]   dkeys[$];

    bit mon_en        = 1'b0;
    int resp_cnt      = 0;
    int last_resp_cyc = -100;
    int done_cyc      = -100;
    int last_rd_hs    = -100;

    task automatic check(input bit ok, input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic check_reset_outs(input string nm);
        logic [63:0] v;
        v = 64'({busy, done, wr_ready, rd_ready, rdata_valid, mem_write, mem_addr, mem_wdata});
        check(v == 64'd0, nm, v, 64'd0);
    endtask

    // Monitor: pops the scoreboards exactly when the DUT should respond.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (wq.size() > 0 && wq[0].c + 1 == cyc) begin
                check(mem_write == 1'b1, "wr_strobe", 64'(mem_write), 64'd1);
                check(mem_addr == wq[0].addr, "wr_addr", 64'(mem_addr), 64'(wq[0].addr));
                check(mem_wdata == wq[0].data, "wr_data", 64'(mem_wdata), 64'(wq[0].data));
                void'(wq.pop_front());
            end else begin
                check(mem_write == 1'b0, "wr_spurious", 64'(mem_write), 64'd0);
            end

            if (rq.size() > 0 && rq[0].c + 2 == cyc) begin
                check(rdata_valid == 1'b1, "rd_valid", 64'(rdata_valid), 64'd1);
                check(rdata == rq[0].data, "rd_data", 64'(rdata), 64'(rq[0].data));
                void'(rq.pop_front());
                resp_cnt++;
                last_resp_cyc = cyc;
            end else begin
                check(rdata_valid == 1'b0, "rd_spurious", 64'(rdata_valid), 64'd0);
            end

            if (resp_cnt == DP && last_resp_cyc + 1 == cyc) begin
                check(done == 1'b1, "done_pulse", 64'(done), 64'd1);
                check(busy == 1'b1, "busy_at_done", 64'(busy), 64'd1);
                done_cyc = cyc;
            end else begin
                check(done == 1'b0, "done_spurious", 64'(done), 64'd0);
            end

            if (done_cyc + 1 == cyc)
                check(busy == 1'b0, "busy_after_done", 64'(busy), 64'd0);
            if (!busy)
                check(!wr_ready && !rd_ready, "ready_idle", 64'({wr_ready, rd_ready}), 64'd0);
            check(!(wr_ready && rd_ready), "ready_excl", 64'({wr_ready, rd_ready}), 64'd1);
`ifndef VMEM_RD_PIPE_EN
            if (rd_ready)
                check(!(cyc - last_rd_hs inside {1, 2}), "rd_ready_inflight",
                      64'(cyc - last_rd_hs), 64'd3);
`endif
        end
    end

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        resp_cnt = 0;
        last_resp_cyc = -100;
        done_cyc = -100;
        @(posedge clk); #1;
        start = 1'b0;
        check(busy && wr_ready, "start_accept", 64'({busy, wr_ready}), 64'd3);
    endtask

    task automatic do_writes(input int gap_pct, input bit seq, input bit junk);
        int n = 0;
        int guard = 0;
        while (n < DP && guard < 2000) begin
            wr_valid = ($urandom_range(99) >= gap_pct);
            wr_data  = seq ? DW'(n) : DW'($urandom);
            if (junk) begin
                start    = 1'($urandom_range(1));
                rd_valid = 1'($urandom_range(1));
                rd_key   = $urandom;
            end
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                wq.push_back('{cyc, AW'(n), wr_data});
                vmodel[n] = wr_data;
                n++;
            end
            @(posedge clk); #1;
            guard++;
        end
        wr_valid = 1'b0;
        start    = 1'b0;
        rd_valid = 1'b0;
        check(n == DP, "wr_beats", 64'(n), 64'(DP));
    endtask

    task automatic do_reads(input int gap_pct, input int abort_after, input bit junk);
        int n = 0;
        int guard = 0;
        int prev = -100;
        while (n < DP && guard < 2000) begin
            if (abort_after > 0 && resp_cnt >= abort_after) break;
            rd_valid = ($urandom_range(99) >= gap_pct);
            rd_key   = (n < dkeys.size()) ? dkeys[n] : $urandom;
            if (junk) begin
                start    = 1'($urandom_range(1));
                wr_valid = 1'($urandom_range(1));
                wr_data  = $urandom;
            end
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                rq.push_back('{cyc, vmodel[rd_key % DP]});
                if (gap_pct == 0 && n > 0)
                    check(cyc - prev == HS_GAP, "rd_hs_spacing", 64'(cyc - prev), 64'(HS_GAP));
                prev = cyc;
                last_rd_hs = cyc;
                n++;
            end
            @(posedge clk); #1;
            guard++;
        end
        rd_valid = 1'b0;
        start    = 1'b0;
        wr_valid = 1'b0;
        if (abort_after == 0) check(n == DP, "rd_requests", 64'(n), 64'(DP));
    endtask

    task automatic wait_done();
        int guard = 0;
        bit seen = 1'b0;
        while (!seen && guard < 40) begin
            @(negedge clk);
            seen = done;
            guard++;
        end
        check(seen, "done_seen", 64'(seen), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check(rq.size() == 0 && wq.size() == 0, "queues_empty",
              64'(rq.size() + wq.size()), 64'd0);
    endtask

    task automatic apply_reset(input string nm);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_outs(nm);
        wq.delete();
        rq.delete();
        resp_cnt = 0;
        last_resp_cyc = -100;
        done_cyc = -100;
        last_rd_hs = -100;
        start = 1'b0;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        @(posedge clk); #1;
        check_reset_outs({nm, "_hold"});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_valid = 1'b0;
        rd_key   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("reset_init");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed job: data = index, keys include one with high bits set.
        dkeys.push_back(32'd15);
        dkeys.push_back(32'd0);
        dkeys.push_back(32'd7);
        dkeys.push_back(32'hFFFF_FFF3);
        dkeys.push_back(32'd3);
        dkeys.push_back(32'h0000_0128);
        do_start();
        do_writes(0, 1'b1, 1'b0);
        do_reads(0, 0, 1'b0);
        wait_done();
        dkeys.delete();

        // Random gaps with illegal inputs sprinkled in.
        do_start();
        do_writes(40, 1'b0, 1'b1);
        do_reads(40, 0, 1'b1);
        wait_done();

        // Async reset mid-READ, then a clean job.
        do_start();
        do_writes(20, 1'b0, 1'b0);
        do_reads(30, 5, 1'b0);
        apply_reset("reset_mid_read");
        do_start();
        do_writes(0, 1'b0, 1'b0);
        do_reads(0, 0, 1'b0);
        wait_done();

        for (int j = 0; j < 3; j++) begin
            do_start();
            do_writes(int'($urandom_range(60)), 1'b0, 1'b1);
            do_reads(int'($urandom_range(60)), 0, 1'b1);
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/romix_vmem_ctrl.md
# romix_vmem_ctrl

Sequencer for the scrypt ROMix scratchpad V held in the single-port 1024-entry BRAM. It runs one ROMix job's memory traffic: first the DEPTH sequential writes V[i] = X, then the DEPTH data-dependent reads V[Integerify(X) mod N]. It sits between the BlockMix datapath (valid/ready streams) and the BRAM port (address, write enable, write data, registered read data).

## Interface
- ADDR_WIDTH, 10, BRAM address width; N = DEPTH = 2^ADDR_WIDTH
- DATA_WIDTH, 1024, scratchpad word width (one 128·r-byte block)
- DEPTH, 1024, scratchpad entries; must equal 2^ADDR_WIDTH

- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  job start pulse; honoured only in IDLE
- o_busy  out  1  high from start accept until done
- o_done  out  1  one-cycle pulse after the last read response
- i_wr_valid  in  1  write beat valid (X from BlockMix)
- i_wr_data  in  DATA_WIDTH  write beat payload
- o_wr_ready  out  1  write beat accepted when valid & ready
- i_rd_valid  in  1  read request valid
- i_rd_key  in  32  Integerify word; low ADDR_WIDTH bits form the index
- o_rd_ready  out  1  read request accepted when valid & ready
- o_rdata_valid  out  1  read response strobe, no backpressure
- o_rdata  out  DATA_WIDTH  read response, V[index]
- o_mem_addr  out  ADDR_WIDTH  to BRAM address, registered
- o_mem_write  out  1  to BRAM write enable, registered
- o_mem_data  out  DATA_WIDTH  to BRAM write data, registered
- i_mem_data  in  DATA_WIDTH  from BRAM read data (1-cycle registered, read-first)

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: o_busy=0, no readies. i_start → WRITE, clear wr_cnt, rd_issued, rd_done.
- WRITE: o_wr_ready=1. Per handshake: o_mem_addr<=wr_cnt, o_mem_write<=1, o_mem_data<=i_wr_data, wr_cnt++. Handshake with wr_cnt==DEPTH-1 → READ. o_mem_write=0 in any cycle following no handshake.
- READ: o_rd_ready per Configuration. Per handshake: o_mem_addr<=i_rd_key[ADDR_WIDTH-1:0] (mod N; upper key bits ignored), o_mem_write<=0, rd_issued++. Handshake with rd_issued==DEPTH-1 → DRAIN.
- DRAIN: no readies; wait until rd_done==DEPTH, then o_done=1 for one cycle and → IDLE.
- o_rdata = i_mem_data; o_rdata_valid tracks a 2-stage shift of read handshakes; rd_done counts strobes (in READ and DRAIN).
- i_start outside IDLE: ignored. i_wr_valid outside WRITE and i_rd_valid outside READ: ignored.
- Counters are ADDR_WIDTH+1 bits; no wrap within a job.

## Timing
- Reset values: o_busy, o_done, o_wr_ready, o_rd_ready, o_rdata_valid, o_mem_write = 0; o_mem_addr, o_mem_data = 0; state IDLE.
- Start accepted cycle t → o_busy=1 and o_wr_ready=1 from t+1.
- Write handshake t → BRAM write strobe at t+1.
- Read handshake t → address at BRAM t+1 → o_rdata_valid=1 with data at t+2.
- Last write at t → earliest read handshake t+1 (address at t+2, after write commits at t+1 edge; no RAW hazard).
- Last response t → o_done=1 at t+1, o_busy=0 and IDLE at t+2.
- Async reset mid-job: immediate return to IDLE, all outputs reset values; partial V contents undefined, no recovery.

## Configuration
- VMEM_RD_PIPE_EN defined: o_rd_ready=1 every READ cycle; back-to-back reads, one response per cycle, up to 2 in flight.
- Undefined: one outstanding read; o_rd_ready=1 only in READ with no read in flight; after a handshake at t, ready low at t+1 and t+2, high again t+3 at earliest.

## Test plan
- Reset: assert i_rst_n=0 mid-clock → all outputs 0 immediately; hold 0 while low.
- Full job, ADDR_WIDTH=4/DEPTH=16: write data=k for k=0..15, read keys 15,0,7,… → each o_rdata equals key index, o_done pulse after 16th response, o_busy falls next cycle.
- Index mod N, DEPTH=16: key 0xFFFF_FFF3 → o_rdata=V[3]; write beats with i_wr_valid gaps → only handshakes write, 16 beats total.
- Illegal inputs: i_start pulses during WRITE/READ and i_rd_valid during WRITE → no state or memory change.
- Pipe on: 16 back-to-back reads → o_rdata_valid high 16 consecutive cycles starting 2 after first handshake; pipe off: handshakes spaced 3 cycles.
- Async reset during READ after 5 responses → IDLE; new i_start runs complete job with correct data.
